uart_tx_serializer: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_tx_serializer.sv | 120 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and types for the UART transmit path
package uart_pkg;

    localparam int DATA_W = 8;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Unknown parity settings fall back to no parity bit.
    function automatic int eff_parity(input int p);
        return (p == PAR_EVEN || p == PAR_ODD) ? p : PAR_NONE;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - per-bit cycle counter, pulses bit_done on the last cycle of each bit
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_done = !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8-bit UART transmitter: start, 8 data LSB first, optional parity, stop
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int PARITY       = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [DATA_W-1:0]   data,
    input  logic                data_ready,
    output logic                busy,
    output logic                tx
);

    localparam int PAR_MODE = eff_parity(PARITY);

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   shift, shift_nxt;
    logic [2:0]          bit_idx, bit_idx_nxt;
    logic                par_acc, par_nxt;
    logic                tx_nxt, busy_nxt;
    logic                baud_clear;
    logic                bit_done;

    // Holding the counter clear in IDLE gives every frame a fresh bit period.
    assign baud_clear = (state == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (baud_clear),
        .bit_done (bit_done)
    );

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_idx_nxt = bit_idx;
        par_nxt     = par_acc;
        tx_nxt      = tx;
        busy_nxt    = busy;
        case (state)
            ST_IDLE: begin
                if (data_ready) begin
                    state_nxt   = ST_START;
                    shift_nxt   = data;
                    bit_idx_nxt = 3'd0;
                    par_nxt     = 1'b0;
                    tx_nxt      = 1'b0;
                    busy_nxt    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_nxt = ST_DATA;
                    tx_nxt    = shift[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    par_nxt     = par_acc ^ shift[0];
                    shift_nxt   = shift >> 1;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        if (PAR_MODE != PAR_NONE) begin
                            state_nxt = ST_PARITY;
                            tx_nxt    = (PAR_MODE == PAR_ODD) ? ~par_nxt : par_nxt;
                        end else begin
                            state_nxt = ST_STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        tx_nxt = shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_nxt = ST_STOP;
                    tx_nxt    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_nxt = ST_IDLE;
                    tx_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // tx resets high through an async set, so an aborted frame never glitches low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            shift   <= '0;
            bit_idx <= 3'd0;
            par_acc <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_idx <= bit_idx_nxt;
            par_acc <= par_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] d [3];
    logic       dr [3];
    logic       tx_w [3];
    logic       busy_w [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .data(d[0]), .data_ready(dr[0]), .busy(busy_w[0]), .tx(tx_w[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .data(d[1]), .data_ready(dr[1]), .busy(busy_w[1]), .tx(tx_w[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .data(d[2]), .data_ready(dr[2]), .busy(busy_w[2]), .tx(tx_w[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame model: a frame is a list of bits, each held CPB cycles from the acceptance edge.
    int         m_busy [3]   = '{0, 0, 0};
    int         m_cyc [3]    = '{0, 0, 0};
    int         m_nbits [3]  = '{10, 11, 11};
    int         m_frames [3] = '{0, 0, 0};
    logic [10:0] m_frame [3];
    int         dut_rises [3] = '{0, 0, 0};
    logic       prev_busy [3] = '{1'b0, 1'b0, 1'b0};

    initial begin
        forever begin
            @(posedge clk or negedge resetn);
            for (int k = 0; k < 3; k++) begin
                if (!resetn) begin
                    m_busy[k] = 0;
                    m_cyc[k]  = 0;
                end else if (m_busy[k] != 0) begin
                    m_cyc[k]++;
                    if (m_cyc[k] == m_nbits[k] * CPB) m_busy[k] = 0;
                end else if (dr[k]) begin
                    m_frame[k] = '1;
                    m_frame[k][0] = 1'b0;
                    for (int i = 0; i < 8; i++) m_frame[k][i+1] = d[k][i];
                    if (k == 1) m_frame[k][9] = ^d[k];
                    if (k == 2) m_frame[k][9] = ~^d[k];
                    m_busy[k] = 1;
                    m_cyc[k]  = 0;
                    m_frames[k]++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("tx_cycle%0d", k), {31'd0, tx_w[k]},
                        {31'd0, (m_busy[k] != 0) ? m_frame[k][m_cyc[k] / CPB] : 1'b1});
                    chk($sformatf("busy_cycle%0d", k), {31'd0, busy_w[k]}, {31'd0, m_busy[k] != 0});
                    if (busy_w[k] === 1'b1 && !prev_busy[k]) dut_rises[k]++;
                    prev_busy[k] = busy_w[k];
                end
            end
        end
    end

    // Sends one byte, samples tx mid-bit into bits[] and counts busy cycles.
    task automatic send(input int inst, input logic [7:0] b, input bit toggle,
                        output logic [10:0] bits, output int busy_cnt);
        @(negedge clk);
        d[inst]  = b;
        dr[inst] = 1'b1;
        @(negedge clk);
        dr[inst] = 1'b0;
        busy_cnt = 0;
        bits     = '1;
        for (int i = 0; i < 120; i++) begin
            if (i > 0) @(negedge clk);
            if (toggle && i == 10) d[inst] = 8'h00;
            if (i % 4 == 2 && i / 4 < 11) bits[i / 4] = tx_w[inst];
            if (busy_w[inst] === 1'b1) busy_cnt++;
            else break;
        end
    endtask

    logic [10:0] bits;
    int          bcnt;
    int          seen;
    int          cyc;
    int          frames_before;
    logic        up_prev;

    initial begin
        resetn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dr[k] = 1'b0;
            d[k]  = 8'h00;
        end
        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_tx%0d", k), {31'd0, tx_w[k]}, 32'd1);
            chk($sformatf("reset_busy%0d", k), {31'd0, busy_w[k]}, 32'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (50) @(negedge clk);
        chk("idle_tx", {31'd0, tx_w[0]}, 32'd1);
        chk("idle_busy", {31'd0, busy_w[0]}, 32'd0);

        send(0, 8'hAB, 1'b0, bits, bcnt);
        chk("ab_bits", {22'd0, bits[9:0]}, {22'd0, 10'b1101010110});
        chk("ab_busy_len", bcnt, 40);

        send(1, 8'hAB, 1'b0, bits, bcnt);
        chk("even_bits", {21'd0, bits}, {21'd0, 11'b11101010110});
        chk("even_parity_bit", {31'd0, bits[9]}, 32'd1);
        chk("even_busy_len", bcnt, 44);

        send(2, 8'hAB, 1'b0, bits, bcnt);
        chk("odd_bits", {21'd0, bits}, {21'd0, 11'b10101010110});
        chk("odd_parity_bit", {31'd0, bits[9]}, 32'd0);
        chk("odd_busy_len", bcnt, 44);

        send(0, 8'h55, 1'b1, bits, bcnt);
        chk("toggle_data_bits", {24'd0, bits[8:1]}, 32'h55);
        chk("toggle_busy_len", bcnt, 40);

        // Upstream byte sender: raise request while idle, drop it once busy is seen.
        frames_before = m_frames[0];
        seen    = 0;
        cyc     = 0;
        up_prev = 1'b0;
        d[0]    = 8'hAB;
        dr[0]   = 1'b1;
        while (seen < 5 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (busy_w[0] === 1'b1 && !up_prev) seen++;
            up_prev = busy_w[0];
            dr[0]   = (busy_w[0] !== 1'b1) && (seen < 5);
        end
        dr[0] = 1'b0;
        chk("upstream_frames", seen, 5);
        chk("upstream_cycles", cyc, 165);
        chk("upstream_model_frames", m_frames[0] - frames_before, 5);
        repeat (50) @(negedge clk);
        chk("upstream_done_busy", {31'd0, busy_w[0]}, 32'd0);

        // Asynchronous reset in the middle of a data bit that is low.
        d[0]  = 8'h55;
        dr[0] = 1'b1;
        @(negedge clk);
        dr[0] = 1'b0;
        repeat (18) @(negedge clk);
        chk("pre_reset_busy", {31'd0, busy_w[0]}, 32'd1);
        chk("pre_reset_tx", {31'd0, tx_w[0]}, 32'd0);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_tx", {31'd0, tx_w[0]}, 32'd1);
        chk("async_reset_busy", {31'd0, busy_w[0]}, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_tx", {31'd0, tx_w[0]}, 32'd1);
        chk("post_reset_busy", {31'd0, busy_w[0]}, 32'd0);

        for (int k = 0; k < 3; k++)
            chk($sformatf("frame_count%0d", k), dut_rises[k], m_frames[k]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
